// File: rtl/inst_fetch.sv
// inst_fetch: single-slot instruction fetch stage with branch redirect, halt at end of memory and error on misaligned target
module inst_fetch #(
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        branch_valid,
  input  logic [5:0]  branch_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  if_pc,
  output logic        halted,
  output logic        err,
  output logic [15:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALT, ERR} state_t;
  state_t state;
  logic [5:0] pc;
  logic hs, redirect, fetch;
  always_comb begin
    hs = if_valid && if_ready;
    redirect = state == RUN && branch_valid;
    fetch = state == RUN && !branch_valid && (!if_valid || if_ready);
  end
  assign imem_addr = pc;
  assign halted = state == HALT && !if_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= '0;
      err <= 1'b0;
      fetch_count <= '0;
    end else if (start && state != RUN) begin
      state <= RUN;
      pc <= RESET_PC;
      if_valid <= 1'b0;
      err <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (hs && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (redirect) begin
        if_valid <= 1'b0;
        if (branch_target[1:0] == 2'b00) pc <= branch_target;
        else begin
          state <= ERR;
          err <= 1'b1;
        end
      end else if (fetch) begin
        if_instr <= imem_data;
        if_pc <= pc;
        if_valid <= 1'b1;
        if (pc == 6'd60) state <= HALT;
        else pc <= pc + 6'd4;
      end else if (hs) if_valid <= 1'b0;
    end
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 6'd0, byte address loaded into PC at reset and on start; SHALL be a multiple of 4.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  one-cycle pulse; begins or restarts fetching at RESET_PC.
REQ-005 Port imem_addr  output  6  byte address to instruction memory.
REQ-006 Port imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 Port branch_valid  input  1  redirect request from execute.
REQ-008 Port branch_target  input  6  redirect byte address.
REQ-009 Port if_valid  output  1  if_instr/if_pc hold a valid instruction for decode.
REQ-010 Port if_ready  input  1  decode accepts the instruction this cycle.
REQ-011 Port if_instr  output  32  registered instruction word.
REQ-012 Port if_pc  output  6  byte address of if_instr.
REQ-013 Port halted  output  1  end of memory reached and output drained.
REQ-014 Port err  output  1  misaligned branch target received.
REQ-015 Port fetch_count  output  16  number of accepted instructions.

Function
REQ-016 The block SHALL implement states IDLE, RUN, HALT and ERR; imem_addr SHALL equal the PC register combinationally in every state.
REQ-017 A fetch SHALL occur in a cycle where state==RUN, branch_valid==0 and (if_valid==0 or if_ready==1): if_instr<=imem_data, if_pc<=PC, if_valid<=1, PC<=PC+4.
REQ-018 If no fetch occurs and if_valid&&if_ready, if_valid SHALL clear next cycle; if if_valid&&!if_ready, if_valid, if_instr and if_pc SHALL hold unchanged.
REQ-019 A fetch at PC==60 SHALL move state to HALT with PC held at 60; PC SHALL never wrap to 0.
REQ-020 In HALT no fetch SHALL occur; the last fetched instruction SHALL remain valid until accepted; halted SHALL be 1 exactly when state==HALT and if_valid==0.
REQ-021 branch_valid in RUN SHALL take priority over fetch and stall: if branch_target[1:0]==0, PC<=branch_target and if_valid<=0 next cycle regardless of if_ready; the first redirected instruction SHALL appear on if_instr two cycles after branch_valid.
REQ-022 branch_valid in RUN with branch_target[1:0]!=0 SHALL move state to ERR, set err=1, clear if_valid and leave PC unchanged.
REQ-023 branch_valid in IDLE, HALT or ERR SHALL be ignored.
REQ-024 start in IDLE, HALT or ERR SHALL, next cycle, set state RUN, PC=RESET_PC, if_valid=0, err=0, fetch_count=0; start in RUN SHALL be ignored.
REQ-025 fetch_count SHALL increment by 1 on each cycle with if_valid&&if_ready and SHALL saturate at 16'hFFFF.
REQ-026 A handshake (if_valid&&if_ready) coinciding with branch_valid SHALL still be counted; the flushed instruction SHALL be considered delivered.

Reset
REQ-027 While rst_n==0, state SHALL be IDLE, PC=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, err=0, fetch_count=0, asynchronously, including mid-fetch or mid-stall.
REQ-028 After rst_n deasserts, no fetch SHALL occur until start is asserted.

Verification
REQ-029 Reset, start, if_ready=1 constant, memory 0xE2901035/0xE0712D01/0xE6042003/0x1AFFFFFD at 0/4/8/12 -> if_instr shows those words with if_pc 0,4,8,12 on consecutive cycles starting one cycle after start's fetch cycle.
REQ-030 if_ready=0 for 3 cycles while if_instr=0xE0712D01 -> if_instr, if_pc=4 and if_valid hold; PC stays 8; fetch_count unchanged.
REQ-031 branch_valid with target 4 while if_pc=8 valid and if_ready=0 -> if_valid=0 next cycle; following cycle if_instr=0xE0712D01, if_pc=4.
REQ-032 branch_valid with target 6 -> err=1, if_valid=0, state ERR; later start -> err=0, fetching resumes at PC 0.
REQ-033 Free-run from 0 with if_ready=1 -> 16 instructions delivered, PC holds 60, halted=1 once drained, fetch_count=16, no further fetches.
REQ-034 rst_n asserted low mid-stall with if_valid=1 -> all outputs immediately at reset values; no fetch after release without start.
